// File: rtl/perf_counter_unit.sv
// perf_counter_unit: memory-mapped performance counters (cycles, instret,
// generic events) with global enable, halt freeze, sticky overflow flags,
// overflow interrupt and a hi-half snapshot for tear-free 32-bit readout.

// One counter: clear beats bus write beats increment.
module perf_cnt_slice #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic             inc,
   input  logic [31:0]      wdata,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);
   // Overflow fires only when the increment actually wins this cycle.
   assign wrap = inc && !clr && !wr_lo && !wr_hi && (&cnt);

   // Counter state update in priority order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cnt <= '0;
      else if (clr)   cnt <= '0;
      else if (wr_lo) cnt[31:0] <= wdata;
      else if (wr_hi) cnt[CNT_W-1:32] <= wdata[CNT_W-33:0];
      else if (inc)   cnt <= cnt + CNT_W'(1);
   end
endmodule

module perf_counter_unit #(
   parameter int          NUM_EVENTS = 4,
   parameter int          CNT_W      = 64,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_1000
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  retire_i,
   input  logic [NUM_EVENTS-1:0] evt_i,
   input  logic                  halt_i,
   input  logic [31:0]           bus_addr_i,
   input  logic                  bus_wvalid_i,
   input  logic [31:0]           bus_wdata_i,
   input  logic                  bus_rvalid_i,
   output logic [31:0]           bus_rdata_o,
   output logic                  bus_rvalid_o,
   output logic                  ovf_irq_o
);
   localparam int NC = NUM_EVENTS + 2;
   localparam int HW = CNT_W - 32;

   logic                      hit, wr, rd, clr, cnt_en;
   logic [5:0]                word;
   logic                      en, irq_en;
   logic [NC-1:0]             ovf, wrap, inc, wr_lo, wr_hi;
   logic [NC-1:0][CNT_W-1:0]  cnt;
   logic [HW-1:0]             snap_hi, lo_upper;
   logic [3:0]                snap_idx, rd_idx;
   logic                      rd_lo;
   logic [31:0]               rd_val;
   logic                      unused_addr_bits;

   // Word-aligned bus: the byte-lane bits carry no information.
   assign unused_addr_bits = ^bus_addr_i[1:0];

   assign hit    = bus_addr_i[31:8] == BASE_ADDR[31:8];
   assign word   = bus_addr_i[7:2];
   assign wr     = bus_wvalid_i && hit;
   assign rd     = bus_rvalid_i && hit;
   assign clr    = wr && (word == 6'd0) && bus_wdata_i[1];
   assign cnt_en = en && !halt_i;
   assign inc    = {evt_i & {NUM_EVENTS{cnt_en}}, cnt_en & retire_i, cnt_en};

   genvar k;
   generate
      for (k = 0; k < NC; k++) begin : g_cnt
         assign wr_lo[k] = wr && (word == 6'(16 + 2*k));
         assign wr_hi[k] = wr && (word == 6'(17 + 2*k));
         perf_cnt_slice #(.CNT_W(CNT_W)) u_slice (
            .clk   (clk_i),
            .rst_n (rst_n_i),
            .clr   (clr),
            .wr_lo (wr_lo[k]),
            .wr_hi (wr_hi[k]),
            .inc   (inc[k]),
            .wdata (bus_wdata_i),
            .cnt   (cnt[k]),
            .wrap  (wrap[k])
         );
      end
   endgenerate

   // Read decode from pre-edge state; a hi read of the snapshotted index
   // returns the value captured by the matching lo read.
   always_comb begin
      rd_val   = '0;
      rd_lo    = 1'b0;
      rd_idx   = '0;
      lo_upper = '0;
      case (word)
         6'd0:    rd_val = {29'd0, irq_en, 1'b0, en};
         6'd1:    rd_val[NC-1:0] = ovf;
         6'd2:    rd_val = {16'd0, 8'(CNT_W), 8'(NC)};
         default: ;
      endcase
      for (int i = 0; i < NC; i++) begin
         if (word == 6'(16 + 2*i)) begin
            rd_val   = cnt[i][31:0];
            rd_lo    = 1'b1;
            rd_idx   = 4'(i);
            lo_upper = cnt[i][CNT_W-1:32];
         end
         if (word == 6'(17 + 2*i))
            rd_val = 32'((snap_idx == 4'(i)) ? snap_hi : cnt[i][CNT_W-1:32]);
      end
   end

   // CTRL register: en resets to 1 so counting starts out of reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         en     <= 1'b1;
         irq_en <= 1'b0;
      end else if (wr && word == 6'd0) begin
         en     <= bus_wdata_i[0];
         irq_en <= bus_wdata_i[2];
      end
   end

   // Sticky overflow flags: a new wrap beats a same-cycle W1C clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                  ovf <= '0;
      else if (clr)                  ovf <= '0;
      else if (wr && word == 6'd1)   ovf <= (ovf & ~bus_wdata_i[NC-1:0]) | wrap;
      else                           ovf <= ovf | wrap;
   end

   // Snapshot of the upper half, taken on every lo counter read.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         snap_hi  <= '0;
         snap_idx <= '0;
      end else if (rd && rd_lo) begin
         snap_hi  <= lo_upper;
         snap_idx <= rd_idx;
      end
   end

   // Registered read response and interrupt; rdata holds between reads.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bus_rdata_o  <= '0;
         bus_rvalid_o <= 1'b0;
         ovf_irq_o    <= 1'b0;
      end else begin
         if (bus_rvalid_i) bus_rdata_o <= rd ? rd_val : 32'd0;
         bus_rvalid_o <= bus_rvalid_i;
         ovf_irq_o    <= irq_en && (|ovf);
      end
   end
endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: directed scenarios plus random traffic,
// every response compared against a register-map level reference model.
module tb_perf_counter_unit;
   localparam int NE = 4;
   localparam int CW = 64;
   localparam int NC = NE + 2;
   localparam logic [31:0] BASE = 32'h8000_1000;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          retire = 1'b0, halt = 1'b0, wv = 1'b0, rv = 1'b0;
   logic [NE-1:0] evt = '0;
   logic [31:0]   addr = '0, wdata = '0;
   logic [31:0]   rdata;
   logic          rvalid, irq;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [63:0]   m_cnt [NC];
   logic [NC-1:0] m_ovf;
   logic          m_en, m_irq_en, m_irq, m_rv;
   logic [31:0]   m_rdata, m_snap_hi;
   int            m_snap_idx;

   always #5 clk = ~clk;

   perf_counter_unit #(.NUM_EVENTS(NE), .CNT_W(CW), .BASE_ADDR(BASE)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .retire_i     (retire),
      .evt_i        (evt),
      .halt_i       (halt),
      .bus_addr_i   (addr),
      .bus_wvalid_i (wv),
      .bus_wdata_i  (wdata),
      .bus_rvalid_i (rv),
      .bus_rdata_o  (rdata),
      .bus_rvalid_o (rvalid),
      .ovf_irq_o    (irq)
   );

   task automatic model_reset();
      for (int j = 0; j < NC; j++) m_cnt[j] = 64'd0;
      m_ovf = '0; m_en = 1'b1; m_irq_en = 1'b0; m_irq = 1'b0; m_rv = 1'b0;
      m_rdata = 32'd0; m_snap_hi = 32'd0; m_snap_idx = 0;
   endtask

   // One bus cycle: drive inputs, advance the model by the register-map
   // rules, then return #1 after the clock edge.
   task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic ret, input logic [NE-1:0] ev,
                      input logic hl);
      logic [31:0]   rdv;
      logic [NC-1:0] novf;
      logic          nirq, clr, isc, hi, hitv, incj;
      int            off, k;
      hitv = (a[31:8] == BASE[31:8]);
      off  = int'(a[7:0]) & 'hFC;
      isc  = hitv && off >= 'h40 && off < 'h40 + 8*NC;
      k    = (off - 'h40) / 8;
      hi   = (off % 8) == 4;
      rdv  = 32'd0;
      if (r && hitv) begin
         if (off == 0)      rdv = {29'd0, m_irq_en, 1'b0, m_en};
         else if (off == 4) rdv = 32'(m_ovf);
         else if (off == 8) rdv = 32'(NC + CW * 256);
         else if (isc && !hi) begin
            rdv = m_cnt[k][31:0];
            m_snap_hi = m_cnt[k][63:32];
            m_snap_idx = k;
         end else if (isc && hi)
            rdv = (m_snap_idx == k) ? m_snap_hi : m_cnt[k][63:32];
      end
      nirq = m_irq_en && (|m_ovf);
      clr  = w && hitv && off == 0 && d[1];
      novf = m_ovf;
      if (w && hitv && off == 4) novf = novf & ~d[NC-1:0];
      for (int j = 0; j < NC; j++) begin
         if (j == 0)      incj = 1'b1;
         else if (j == 1) incj = ret;
         else             incj = ev[j-2];
         incj = incj && m_en && !hl;
         if (clr) m_cnt[j] = 64'd0;
         else if (w && isc && k == j) begin
            if (hi) m_cnt[j][63:32] = d;
            else    m_cnt[j][31:0]  = d;
         end else if (incj) begin
            m_cnt[j] = m_cnt[j] + 64'd1;
            if (m_cnt[j] == 64'd0) novf[j] = 1'b1;
         end
      end
      if (clr) novf = '0;
      m_ovf = novf;
      if (w && hitv && off == 0) begin m_en = d[0]; m_irq_en = d[2]; end
      wv = w; rv = r; addr = a; wdata = d; retire = ret; evt = ev; halt = hl;
      @(posedge clk);
      #1;
      m_rv = r;
      if (r) m_rdata = rdv;
      m_irq = nirq;
      wv = 1'b0; rv = 1'b0;
   endtask

   task automatic rd_cyc(input logic [31:0] a);
      cyc(1'b0, 1'b1, a, 32'd0, 1'b0, '0, 1'b0);
   endtask

   task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d);
      cyc(1'b1, 1'b0, a, d, 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset();
      #22;
      total++;
      if (rdata !== 32'd0 || rvalid !== 1'b0 || irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: rdata=%h rvalid=%b irq=%b want 0/0/0", rdata, rvalid, irq);
      end
      model_reset();
      rst_n = 1'b1;
      rd_cyc(BASE + 32'h00);
      total++;
      if (rdata !== 32'h1 || rvalid !== 1'b1) begin
         bad++; $display("FAIL reset_ctrl: got %h/%b want 1/1", rdata, rvalid);
      end
      rd_cyc(BASE + 32'h04);
      total++;
      if (rdata !== 32'h0) begin bad++; $display("FAIL reset_ovf: got %h want 0", rdata); end
   endtask

   task automatic test_basic_count();
      wr_cyc(BASE, 32'h3);
      for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, BASE, 32'd0, (i % 2) == 0, '0, 1'b0);
      rd_cyc(BASE + 32'h40);
      total++;
      if (rdata !== 32'd100 || rvalid !== 1'b1 || rdata !== m_rdata) begin
         bad++; $display("FAIL basic_cycles: got %0d rv=%b want 100 rv=1", rdata, rvalid);
      end
      cyc(1'b0, 1'b0, BASE, 32'd0, 1'b0, '0, 1'b0);
      total++;
      if (rvalid !== 1'b0) begin bad++; $display("FAIL basic_rvalid_pulse: got %b want 0", rvalid); end
      rd_cyc(BASE + 32'h48);
      total++;
      if (rdata !== 32'd50 || rdata !== m_rdata) begin
         bad++; $display("FAIL basic_instret: got %0d want 50", rdata);
      end
   endtask

   task automatic test_overflow();
      wr_cyc(BASE, 32'h5);
      wr_cyc(BASE + 32'h40, 32'hFFFF_FFFF);
      wr_cyc(BASE + 32'h44, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b0, BASE, 32'd0, 1'b0, '0, 1'b0);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL ovf_irq_early: got %b want 0", irq); end
      rd_cyc(BASE + 32'h04);
      total++;
      if (rdata !== 32'h1 || irq !== 1'b1 || irq !== m_irq) begin
         bad++; $display("FAIL ovf_set: ovf=%h irq=%b want 1/1", rdata, irq);
      end
      rd_cyc(BASE + 32'h40);
      total++;
      if (rdata !== 32'd1 || rdata !== m_rdata) begin
         bad++; $display("FAIL ovf_wrap_value: got %h want 1", rdata);
      end
      wr_cyc(BASE + 32'h04, 32'h1);
      rd_cyc(BASE + 32'h04);
      total++;
      if (rdata !== 32'h0 || irq !== 1'b0) begin
         bad++; $display("FAIL ovf_w1c: ovf=%h irq=%b want 0/0", rdata, irq);
      end
      // counter 3 wraps on the same edge that software tries to clear it
      wr_cyc(BASE + 32'h5C, 32'hFFFF_FFFF);
      wr_cyc(BASE + 32'h58, 32'hFFFF_FFFF);
      cyc(1'b1, 1'b0, BASE + 32'h04, 32'h8, 1'b0, 4'b0010, 1'b0);
      rd_cyc(BASE + 32'h04);
      total++;
      if (rdata !== 32'h8 || rdata !== m_rdata) begin
         bad++; $display("FAIL ovf_set_beats_clear: got %h want 8", rdata);
      end
      wr_cyc(BASE + 32'h04, 32'h3F);
      wr_cyc(BASE, 32'h1);
   endtask

   task automatic test_snapshot();
      wr_cyc(BASE + 32'h54, 32'h0);
      wr_cyc(BASE + 32'h50, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b0, BASE, 32'd0, 1'b0, 4'b0001, 1'b0);
      rd_cyc(BASE + 32'h50);
      total++;
      if (rdata !== 32'h0) begin bad++; $display("FAIL snap_lo: got %h want 0", rdata); end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, BASE, 32'd0, 1'b0, 4'b0001, 1'b0);
      wr_cyc(BASE + 32'h54, 32'h7);
      rd_cyc(BASE + 32'h54);
      total++;
      if (rdata !== 32'h1 || m_cnt[2] !== 64'h7_0000_0003) begin
         bad++; $display("FAIL snap_hi_held: got %h want 1", rdata);
      end
      rd_cyc(BASE + 32'h5C);
      total++;
      if (rdata !== m_rdata) begin bad++; $display("FAIL snap_other_live: got %h want %h", rdata, m_rdata); end
      rd_cyc(BASE + 32'h50);
      total++;
      if (rdata !== 32'h3) begin bad++; $display("FAIL snap_relo: got %h want 3", rdata); end
      rd_cyc(BASE + 32'h54);
      total++;
      if (rdata !== 32'h7) begin bad++; $display("FAIL snap_rehi: got %h want 7", rdata); end
   endtask

   task automatic test_halt_en();
      logic [63:0] s0, s1;
      s0 = m_cnt[0]; s1 = m_cnt[1];
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, BASE, 32'd0, 1'b1, 4'hF, 1'b1);
      cyc(1'b0, 1'b1, BASE + 32'h40, 32'd0, 1'b1, 4'hF, 1'b1);
      total++;
      if (rdata !== s0[31:0]) begin bad++; $display("FAIL halt_cycles: got %h want %h", rdata, s0[31:0]); end
      cyc(1'b0, 1'b1, BASE + 32'h48, 32'd0, 1'b1, 4'hF, 1'b1);
      total++;
      if (rdata !== s1[31:0]) begin bad++; $display("FAIL halt_instret: got %h want %h", rdata, s1[31:0]); end
      wr_cyc(BASE, 32'h0);
      s0 = m_cnt[0];
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, BASE, 32'd0, 1'b1, 4'hF, 1'b0);
      rd_cyc(BASE + 32'h40);
      total++;
      if (rdata !== s0[31:0] || rdata !== m_rdata) begin
         bad++; $display("FAIL en0_cycles: got %h want %h", rdata, s0[31:0]);
      end
      wr_cyc(BASE, 32'h1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, BASE, 32'd0, 1'b0, '0, 1'b0);
      rd_cyc(BASE + 32'h40);
      total++;
      if (rdata !== s0[31:0] + 32'd5) begin
         bad++; $display("FAIL resume_cycles: got %h want %h", rdata, s0[31:0] + 32'd5);
      end
   endtask

   task automatic test_same_cycle();
      cyc(1'b1, 1'b0, BASE, 32'h3, 1'b1, 4'hF, 1'b0);
      for (int j = 1; j < NC; j++) begin
         rd_cyc(BASE + 32'h40 + 32'(8*j));
         total++;
         if (rdata !== 32'd0) begin bad++; $display("FAIL clr_cnt%0d: got %h want 0", j, rdata); end
      end
      cyc(1'b1, 1'b0, BASE + 32'h50, 32'h1234, 1'b1, 4'h1, 1'b0);
      rd_cyc(BASE + 32'h50);
      total++;
      if (rdata !== 32'h1234) begin bad++; $display("FAIL write_beats_inc: got %h want 1234", rdata); end
      cyc(1'b1, 1'b1, BASE + 32'h58, 32'hABCD, 1'b0, '0, 1'b0);
      total++;
      if (rdata !== 32'h0) begin bad++; $display("FAIL rw_prewrite: got %h want 0", rdata); end
      rd_cyc(BASE + 32'h58);
      total++;
      if (rdata !== 32'hABCD) begin bad++; $display("FAIL rw_postwrite: got %h want abcd", rdata); end
   endtask

   task automatic test_info_unmapped();
      rd_cyc(BASE + 32'h08);
      total++;
      if (rdata !== 32'h4006) begin bad++; $display("FAIL info: got %h want 4006", rdata); end
      rd_cyc(BASE + 32'h80);
      total++;
      if (rdata !== 32'h0) begin bad++; $display("FAIL unmapped_80: got %h want 0", rdata); end
      wr_cyc(BASE + 32'h08, 32'hFFFF_FFFF);
      wr_cyc(BASE + 32'h80, 32'hFFFF_FFFF);
      rd_cyc(BASE + 32'h08);
      total++;
      if (rdata !== 32'h4006) begin bad++; $display("FAIL info_ro: got %h want 4006", rdata); end
      rd_cyc(32'h8000_2040);
      total++;
      if (rdata !== 32'h0 || rvalid !== 1'b1) begin
         bad++; $display("FAIL off_base: got %h rv=%b want 0/1", rdata, rvalid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         cyc(1'b0, 1'b1, BASE + 32'h40 + 32'(4 * (i % (2*NC))), 32'd0,
             1'($urandom_range(0, 1)), 4'($urandom), 1'b0);
         total++;
         if (rvalid !== 1'b1 || rdata !== m_rdata) begin
            bad++; $display("FAIL b2b_%0d: got %h rv=%b want %h rv=1", i, rdata, rvalid, m_rdata);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      logic        w;
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 9))
            0:       a = BASE;
            1:       a = BASE + 32'h04;
            2:       a = BASE + 32'h08;
            3:       a = BASE + 32'(4 * $urandom_range(0, 63));
            default: a = BASE + 32'h40 + 32'(4 * $urandom_range(0, 2*NC - 1));
         endcase
         d = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
         w = ($urandom_range(0, 5) == 0);
         if (a == BASE) d = {29'd0, d[2], ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) != 0)};
         cyc(w, 1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)), 4'($urandom),
             ($urandom_range(0, 9) == 0));
         total++;
         if (rvalid !== m_rv || rdata !== m_rdata || irq !== m_irq) begin
            bad++;
            $display("FAIL rand_%0d: rdata=%h rv=%b irq=%b want %h/%b/%b", i, rdata, rvalid, irq,
                     m_rdata, m_rv, m_irq);
         end
      end
   endtask

   task automatic test_reset_async();
      rd_cyc(BASE + 32'h08);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (rdata !== 32'd0 || rvalid !== 1'b0 || irq !== 1'b0) begin
         bad++; $display("FAIL async_reset: rdata=%h rv=%b irq=%b want 0/0/0", rdata, rvalid, irq);
      end
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      m_cnt[0] = 64'd1;
      rd_cyc(BASE + 32'h40);
      total++;
      if (rdata !== 32'd1) begin bad++; $display("FAIL post_reset_cycles: got %0d want 1", rdata); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_count();
      test_overflow();
      test_snapshot();
      test_halt_en();
      test_same_cycle();
      test_info_unmapped();
      test_back_to_back();
      test_random();
      test_reset_async();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/perf_counter_unit.md
# perf_counter_unit

Synthesizable, memory-mapped hardware performance counter block that replaces testbench-only cycle/instret/branch counting. Sits beside the CPU on the data bus. Counts a fixed cycle counter, a retired-instruction counter and `NUM_EVENTS` generic event inputs (e.g. branch predictions, mispredictions, stalls) into `CNT_W`-bit counters. Supports global enable, halt-freeze, overflow flags and tear-free 32-bit readout of wide counters.

## Interface
Parameters:
- `NUM_EVENTS`, 4: generic event inputs/counters, range 1..14; total counters `NC = NUM_EVENTS+2`.
- `CNT_W`, 64: counter width, range 33..64.
- `BASE_ADDR`, 32'h8000_1000: decode base; block occupies 256 bytes.

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `retire_i` in 1: one instruction retired this cycle.
- `evt_i` in NUM_EVENTS: per-cycle event strobes; bit k feeds counter k+2.
- `halt_i` in 1: freezes all counting while high (sim-finish / debug halt).
- `bus_addr_i` in 32: byte address; word-aligned, bits [1:0] ignored.
- `bus_wvalid_i` in 1: write strobe, one cycle, always accepted.
- `bus_wdata_i` in 32: write data.
- `bus_rvalid_i` in 1: read request strobe, always accepted.
- `bus_rdata_o` out 32: read data, registered.
- `bus_rvalid_o` out 1: read data valid pulse.
- `ovf_irq_o` out 1: OR of all overflow flags masked by CTRL.irq_en.

## Operation
- Decode hits when `bus_addr_i[31:8] == BASE_ADDR[31:8]`; offset = `bus_addr_i[7:0]`.
- Register map:
  - 0x00 CTRL: bit0 `en` (reset 1), bit1 `clr` (write-1, self-clearing, reads 0), bit2 `irq_en` (reset 0).
  - 0x04 OVF: bit k = sticky overflow of counter k; write-1-to-clear.
  - 0x08 INFO, RO: [7:0]=NC, [15:8]=CNT_W.
  - 0x40+8k (k<NC): counter k bits [31:0]. 0x44+8k: counter k bits [CNT_W-1:32], zero-extended.
  - Counter 0 = cycles, 1 = instret, k+2 = `evt_i[k]`.
- Counting when `en && !halt_i`: cnt0 += 1; cnt1 += `retire_i`; cnt(k+2) += `evt_i[k]`.
- Wrap: all-ones + 1 -> 0 and sets OVF[k] that same edge.
- Counter writes: lo write replaces bits [31:0]; hi write replaces upper bits (excess wdata bits dropped). Other half unchanged.
- Snapshot: any lo read captures that counter's upper bits plus index into `snap_hi/snap_idx`. A hi read of the same index returns `snap_hi`; a hi read of any other index returns live upper bits. Snapshot is held until the next lo read.
- Unmapped offsets, or k >= NC: reads return 0; writes are ignored. Writes to INFO are ignored.
- Priority in one cycle, per counter: `clr` > bus write > increment. Losers are discarded (no increment on a write cycle).
- OVF: a new overflow set beats a W1C clear of the same bit. `clr` also clears OVF.
- Simultaneous `bus_wvalid_i` and `bus_rvalid_i`: both served; the read returns the pre-write value.

## Timing
- Reset, async assert: all counters 0, OVF 0, CTRL = 0x1, snapshot 0, `bus_rdata_o` = 0, `bus_rvalid_o` = 0, `ovf_irq_o` = 0. Deassertion is synchronous to `clk_i` by use.
- Read latency is 1 cycle: request at edge N gives `bus_rvalid_o` = 1 with data for cycle N+1 only. `bus_rdata_o` holds its value between reads.
- Read value is the counter state before edge N's update.
- Write takes effect at the edge where `bus_wvalid_i` is sampled. The counter then resumes incrementing from the written value next cycle.
- `en`/`halt_i` changes take effect the same edge they are sampled: the counter does not advance on a cycle where the sampled value disables it.
- `ovf_irq_o` is registered: it rises 1 cycle after the overflow edge when `irq_en` = 1.
- Back-to-back reads every cycle are supported at full throughput.

## Test plan
- Reset, then 100 cycles with `en` = 1, `halt_i` = 0 and `retire_i` high every other cycle -> read 0x40 = 100 (±read-cycle offset documented), 0x48 = 50; `bus_rvalid_o` is 1 cycle after each request.
- Write 0x40 = 0xFFFF_FFFF and 0x44 = 0xFFFF_FFFF (CNT_W = 64), then 1 counting cycle -> cnt0 = 0 and OVF = 0x1. With `irq_en` = 1, `ovf_irq_o` goes high the next cycle. Write OVF = 0x1 -> OVF = 0 and irq drops.
- Set cnt2 = 0x0000_0000_FFFF_FFFF and pulse `evt_i[0]`. Read 0x50 (gives 0x0000_0000), advance 3 events, read 0x54 -> 0x1 (snapshot), while the live value is 0x1_0000_0003.
- `halt_i` high for 20 cycles, then `en` = 0 for 20 cycles -> no counter changes; resume -> increments continue from the held values.
- Same cycle: `clr` write plus events -> all counters 0. Same cycle: counter write plus event -> written value exactly.
- Read 0x08 -> {CNT_W, NC} (e.g. 0x4006 for defaults). Read 0x80 with NC = 6 -> 0. Write 0x08 -> INFO unchanged.
